// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] opd,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] diff_s;

  // Compute both step flavours and pick one; {acc,q} is the working pair.
  always_comb begin
    sum_s    = {1'b0, acc} + (q[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
    rem_sh_s = {acc, q[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, opd};
    if (is_div) begin
      if (!diff_s[XLEN]) begin
        acc_next = diff_s[XLEN-1:0];
        q_next   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = rem_sh_s[XLEN-1:0];
        q_next   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = sum_s[XLEN:1];
      q_next   = {sum_s[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Operands are reduced to magnitudes on accept and the sign is restored in FIX.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] twos(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      fn_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] opb_r;
  logic            neg_res_r;
  logic            neg_rem_r;

  logic            a_signed_s;
  logic            b_signed_s;
  logic            neg_a_s;
  logic            neg_b_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic [XLEN-1:0] acc_nxt_s;
  logic [XLEN-1:0] q_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;
  logic [XLEN-1:0] fix_s;

  // Operand sign handling and special-case detection for an incoming request.
  always_comb begin
    a_signed_s = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
                 (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
    b_signed_s = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    neg_a_s    = a_signed_s & op1[XLEN-1];
    neg_b_s    = b_signed_s & op2[XLEN-1];
    mag_a_s    = neg_a_s ? twos(op1) : op1;
    mag_b_s    = neg_b_s ? twos(op2) : op2;
    div_zero_s = op_is_div(funct3) && (op2 == {XLEN{1'b0}});
    ovf_s      = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                 (op1 == MIN_VAL) && (op2 == ALL_ONES);
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .is_div   (op_is_div(fn_r)),
    .acc      (acc_r),
    .q        (q_r),
    .opd      (opb_r),
    .acc_next (acc_nxt_s),
    .q_next   (q_nxt_s)
  );

  // Sign restoration and result selection applied in FIX.
  always_comb begin
    prod_s     = {acc_r, q_r};
    prod_fix_s = neg_res_r ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
    quo_fix_s  = neg_res_r ? twos(q_r) : q_r;
    rem_fix_s  = neg_rem_r ? twos(acc_r) : acc_r;
    case (fn_r)
      MDU_MUL:                        fix_s = prod_fix_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_s = prod_fix_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              fix_s = quo_fix_s;
      MDU_REM, MDU_REMU:              fix_s = rem_fix_s;
      default:                        fix_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM, iteration registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      fn_r      <= 3'b000;
      acc_r     <= {XLEN{1'b0}};
      q_r       <= {XLEN{1'b0}};
      opb_r     <= {XLEN{1'b0}};
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result    <= {XLEN{1'b0}};
      done      <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
    end else if (kill) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      done    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            fn_r  <= funct3;
            cnt_r <= {CW{1'b0}};
            ready <= 1'b0;
            busy  <= 1'b1;
            // Special cases preload the answer so FIX passes it straight through.
            if (div_zero_s) begin
              state_r   <= S_FIX;
              q_r       <= ALL_ONES;
              acc_r     <= op1;
              neg_res_r <= 1'b0;
              neg_rem_r <= 1'b0;
            end else if (ovf_s) begin
              state_r   <= S_FIX;
              q_r       <= MIN_VAL;
              acc_r     <= {XLEN{1'b0}};
              neg_res_r <= 1'b0;
              neg_rem_r <= 1'b0;
            end else begin
              state_r   <= S_CALC;
              q_r       <= mag_a_s;
              acc_r     <= {XLEN{1'b0}};
              opb_r     <= mag_b_s;
              neg_res_r <= neg_a_s ^ neg_b_s;
              neg_rem_r <= neg_a_s;
            end
          end else begin
            state_r <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
          end
        end
        S_CALC: begin
          acc_r <= acc_nxt_s;
          q_r   <= q_nxt_s;
          if (cnt_r == CW'(XLEN-1)) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= S_FIX;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_FIX: begin
          result  <= fix_s;
          done    <= 1'b1;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_DONE;
        end
        default: begin
          state_r <= S_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit plus kill/reset/handshake sequences.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op1 = 32'h0;
  logic [31:0] op2 = 32'h0;
  logic        kill = 1'b0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
    .kill(kill), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge where done is seen.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcnt);
    funct3 = f; op1 = a; op2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  logic [31:0] res;
  logic [31:0] saved;
  int lat;
  int bcnt;

  initial begin
    vecs.push_back('{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34});
    vecs.push_back('{3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 34});
    vecs.push_back('{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 34});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34});
    vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       34});
    vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        34});
    vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 34});
    vecs.push_back('{3'b100, 32'h80000000, 32'h00000001, 32'h80000000, 34});
    vecs.push_back('{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34});
    vecs.push_back('{3'b100, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 2});
    vecs.push_back('{3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 2});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 2});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2});

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bcnt);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].lat - 1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("vec%0d_result_hold", i), result, vecs[i].exp);
    end

    // kill ten cycles into a DIV: no done, idle next cycle, result kept
    saved = result;
    funct3 = 3'b101; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", {31'd0, ready}, 32'd1);
    chk("kill_busy", {31'd0, busy}, 32'd0);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) lat++;
      @(negedge clk);
    end
    chk("kill_no_done", lat, 0);
    chk("kill_result_kept", result, saved);

    // start while busy is ignored
    funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    funct3 = 3'b100; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    repeat (3) begin @(negedge clk); lat++; end
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    chk("busy_start_latency", lat, 34);
    chk("busy_start_result", result, 32'd14);

    // back-to-back: start issued in the done cycle
    do_op(3'b000, 32'd3, 32'd5, res, lat, bcnt);
    chk("b2b_latency", lat, 34);
    chk("b2b_result", res, 32'd15);
    @(negedge clk);

    // reset in the middle of a MUL
    funct3 = 3'b000; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int c = 0; c < 25; c++) begin
      if (done === 1'b1) lat++;
      @(negedge clk);
    end
    chk("midrst_no_done", lat, 0);
    do_op(3'b011, 32'h00000004, 32'h40000000, res, lat, bcnt);
    chk("post_rst_latency", lat, 34);
    chk("post_rst_result", res, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
